// File: rtl/cafv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cafv_pkg
// Description : Shared width helpers for the CAF front-end datapath
//               (complex dot product and correlator bank).
// Revision    : 1.0 - initial release
// ============================================================================
package cafv_pkg;

  // Ceiling log2; returns 0 for n <= 1 so a single-lane tree has no stages.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  // Width of one complex-product component: a*b +/- c*d, full precision.
  function automatic int prod_bits(input int xb, input int yb);
    return xb + yb + 1;
  endfunction

  // Width of the adder-tree root after summing len products.
  function automatic int sum_bits(input int xb, input int yb, input int len);
    return prod_bits(xb, yb) + clog2(len);
  endfunction

  // Number of elements left in a tree level after repeated pairing.
  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage : cafv_pkg
`default_nettype wire

// File: rtl/cpx_dot_prod_pipe_if.sv
`default_nettype none
// ============================================================================
// Interface   : cpx_dot_prod_pipe_if
// Description : Input-beat and result streams of the complex dot product.
//               master = sample source / result sink, slave = the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface cpx_dot_prod_pipe_if
  import cafv_pkg::*;
#(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12,
  parameter int LENGTH = 5
);
  localparam int C_SUM_BITS = sum_bits(X_BITS, Y_BITS, LENGTH);

  logic                         m_axis_x_tvalid;
  logic                         m_axis_y_tvalid;
  logic                         m_axis_tready;
  logic                         conj_y;
  logic [X_BITS*LENGTH-1:0]     xi;
  logic [X_BITS*LENGTH-1:0]     xq;
  logic [Y_BITS*LENGTH-1:0]     yi;
  logic [Y_BITS*LENGTH-1:0]     yq;
  logic                         s_axis_tvalid;
  logic                         s_axis_tready;
  logic [C_SUM_BITS-1:0]        i;
  logic [C_SUM_BITS-1:0]        q;

  modport master (
    output m_axis_x_tvalid, m_axis_y_tvalid, conj_y, xi, xq, yi, yq, s_axis_tready,
    input  m_axis_tready, s_axis_tvalid, i, q
  );

  modport slave (
    input  m_axis_x_tvalid, m_axis_y_tvalid, conj_y, xi, xq, yi, yq, s_axis_tready,
    output m_axis_tready, s_axis_tvalid, i, q
  );

endinterface : cpx_dot_prod_pipe_if
`default_nettype wire

// File: rtl/cpx_mult_reg.sv
`default_nettype none
// ============================================================================
// Module      : cpx_mult_reg
// Description : One lane of the dot product: complex multiply of x by y or
//               conj(y), registered with its valid bit under the global stall.
// Revision    : 1.0 - initial release
// ============================================================================
module cpx_mult_reg
  import cafv_pkg::*;
#(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      advance,
  input  logic                                      load,
  input  logic                                      conj_y,
  input  logic signed [X_BITS-1:0]                  xi,
  input  logic signed [X_BITS-1:0]                  xq,
  input  logic signed [Y_BITS-1:0]                  yi,
  input  logic signed [Y_BITS-1:0]                  yq,
  output logic signed [prod_bits(X_BITS, Y_BITS)-1:0] pr,
  output logic signed [prod_bits(X_BITS, Y_BITS)-1:0] pi,
  output logic                                      valid
);
  localparam int C_PB = prod_bits(X_BITS, Y_BITS);

  logic signed [C_PB-1:0] w_xi, w_xq, w_yi, w_yq;
  logic signed [C_PB-1:0] w_ii, w_qq, w_iq, w_qi;
  logic signed [C_PB-1:0] w_re, w_im;

  // Operands are sign-extended to the product width so every partial product
  // and the final add/sub are exact.
  assign w_xi = C_PB'(xi);
  assign w_xq = C_PB'(xq);
  assign w_yi = C_PB'(yi);
  assign w_yq = C_PB'(yq);

  assign w_ii = w_xi * w_yi;
  assign w_qq = w_xq * w_yq;
  assign w_iq = w_xi * w_yq;
  assign w_qi = w_xq * w_yi;

  // Conjugating y flips the sign of its imaginary part in both sums.
  always_comb begin
    w_re = w_ii - w_qq;
    w_im = w_iq + w_qi;
    if (conj_y) begin
      w_re = w_ii + w_qq;
      w_im = w_qi - w_iq;
    end
  end

  // Product register: valid follows the accept on every advance; data is only
  // loaded for a real beat so a half-presented beat leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      pr    <= '0;
      pi    <= '0;
    end else if (advance) begin
      valid <= load;
      if (load) begin
        pr <= w_re;
        pi <= w_im;
      end
    end
  end

endmodule : cpx_mult_reg
`default_nettype wire

// File: rtl/cpx_dot_prod_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cpx_dot_prod_pipe
// Description : Pipelined complex dot product over LENGTH lanes with a
//               registered full-precision adder tree, per-beat conj(y) and
//               valid/ready flow control driven by a single global stall.
// Revision    : 1.0 - initial release
// ============================================================================
module cpx_dot_prod_pipe
  import cafv_pkg::*;
#(
  parameter int X_BITS = 12,
  parameter int Y_BITS = 12,
  parameter int LENGTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  cpx_dot_prod_pipe_if.slave   bus
);
  localparam int C_DEPTH     = clog2(LENGTH);
  localparam int C_PROD_BITS = prod_bits(X_BITS, Y_BITS);
  localparam int C_SUM_BITS  = sum_bits(X_BITS, Y_BITS, LENGTH);

  logic                          w_advance;
  logic                          w_beat;
  logic                          r_out_vld;
  logic signed [C_SUM_BITS-1:0]  r_out_re;
  logic signed [C_SUM_BITS-1:0]  r_out_im;

  // The whole pipe moves together; it only freezes when a result is stuck.
  assign w_advance         = !r_out_vld | bus.s_axis_tready;
  assign w_beat            = bus.m_axis_x_tvalid & bus.m_axis_y_tvalid;
  assign bus.m_axis_tready = w_advance;
  assign bus.s_axis_tvalid = r_out_vld;
  assign bus.i             = r_out_re;
  assign bus.q             = r_out_im;

  // Level 0 is the product register; level l holds ceil(LENGTH/2^l) partial
  // sums one bit wider than level l-1.
  for (genvar l = 0; l <= C_DEPTH; l++) begin : g_lvl
    localparam int C_LW = C_PROD_BITS + l;
    localparam int C_LN = ceil_div(LENGTH, 1 << l);

    logic signed [C_LW-1:0] r_re [C_LN];
    logic signed [C_LW-1:0] r_im [C_LN];
    logic                   r_vld;

    if (l == 0) begin : g_leaf
      logic [LENGTH-1:0] w_lane_vld;

      for (genvar k = 0; k < LENGTH; k++) begin : g_lane
        cpx_mult_reg #(
          .X_BITS (X_BITS),
          .Y_BITS (Y_BITS)
        ) u_mult (
          .clk     (clk),
          .rst     (rst),
          .advance (w_advance),
          .load    (w_beat),
          .conj_y  (bus.conj_y),
          .xi      (bus.xi[X_BITS*k +: X_BITS]),
          .xq      (bus.xq[X_BITS*k +: X_BITS]),
          .yi      (bus.yi[Y_BITS*k +: Y_BITS]),
          .yq      (bus.yq[Y_BITS*k +: Y_BITS]),
          .pr      (r_re[k]),
          .pi      (r_im[k]),
          .valid   (w_lane_vld[k])
        );
      end

      // All lanes load in lock-step, so their valid bits are identical.
      assign r_vld = &w_lane_vld;
    end else begin : g_node
      localparam int C_PN = ceil_div(LENGTH, 1 << (l - 1));

      logic signed [C_LW-1:0] w_re [C_LN];
      logic signed [C_LW-1:0] w_im [C_LN];

      for (genvar k = 0; k < C_LN; k++) begin : g_el
        if (2 * k + 1 < C_PN) begin : g_pair
          assign w_re[k] = C_LW'(g_lvl[l-1].r_re[2*k]) + C_LW'(g_lvl[l-1].r_re[2*k+1]);
          assign w_im[k] = C_LW'(g_lvl[l-1].r_im[2*k]) + C_LW'(g_lvl[l-1].r_im[2*k+1]);
        end else begin : g_odd
          assign w_re[k] = C_LW'(g_lvl[l-1].r_re[2*k]);
          assign w_im[k] = C_LW'(g_lvl[l-1].r_im[2*k]);
        end
      end

      // Tree stage register with its valid bit, frozen during a stall.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= 1'b0;
          for (int k = 0; k < C_LN; k++) begin
            r_re[k] <= '0;
            r_im[k] <= '0;
          end
        end else if (w_advance) begin
          r_vld <= g_lvl[l-1].r_vld;
          r_re  <= w_re;
          r_im  <= w_im;
        end
      end
    end
  end

  // Output register: captures the tree root; a handshake with no new root
  // data clears the valid, a stall holds everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_vld <= 1'b0;
      r_out_re  <= '0;
      r_out_im  <= '0;
    end else if (w_advance) begin
      r_out_vld <= g_lvl[C_DEPTH].r_vld;
      r_out_re  <= g_lvl[C_DEPTH].r_re[0];
      r_out_im  <= g_lvl[C_DEPTH].r_im[0];
    end
  end

endmodule : cpx_dot_prod_pipe
`default_nettype wire

// File: tb/tb_cpx_dot_prod_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpx_dot_prod_pipe
// Description : Self-checking bench: 4-lane 8-bit instance with a running
//               reference model and scoreboard, plus a 5-lane 12-bit instance
//               for the odd-lane tree and its latency.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpx_dot_prod_pipe;

  typedef struct {
    longint re;
    longint im;
  } res_t;

  typedef int lane_t [8];

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  res_t exp_q [$];
  bit   held;
  longint held_i, held_q;
  lane_t  mon_xr, mon_xm, mon_yr, mon_ym;
  res_t   mon_e;

  cpx_dot_prod_pipe_if #(.X_BITS(8),  .Y_BITS(8),  .LENGTH(4)) bus_a ();
  cpx_dot_prod_pipe_if #(.X_BITS(12), .Y_BITS(12), .LENGTH(5)) bus_b ();

  cpx_dot_prod_pipe #(.X_BITS(8), .Y_BITS(8), .LENGTH(4)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  cpx_dot_prod_pipe #(.X_BITS(12), .Y_BITS(12), .LENGTH(5)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: straight complex sum of x*y (or x*conj(y)) over n lanes.
  function automatic res_t model(input lane_t xr, input lane_t xm, input lane_t yr,
                                 input lane_t ym, input int n, input bit cj);
    res_t r;
    longint a, b, c, d;
    r.re = 0;
    r.im = 0;
    for (int k = 0; k < n; k++) begin
      a = xr[k]; b = xm[k]; c = yr[k]; d = ym[k];
      if (!cj) begin
        r.re += a * c - b * d;
        r.im += a * d + b * c;
      end else begin
        r.re += a * c + b * d;
        r.im += b * c - a * d;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint a_i();
    return longint'($signed(bus_a.i));
  endfunction
  function automatic longint a_q();
    return longint'($signed(bus_a.q));
  endfunction
  function automatic longint b_i();
    return longint'($signed(bus_b.i));
  endfunction
  function automatic longint b_q();
    return longint'($signed(bus_b.q));
  endfunction

  // Scoreboard for instance A: predicts each accepted beat and checks results
  // in order, plus the hold-while-stalled rule.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", longint'(bus_a.s_axis_tvalid), 1);
        chk("hold_i", a_i(), held_i);
        chk("hold_q", a_q(), held_q);
      end
      if (bus_a.s_axis_tvalid && bus_a.s_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_i", a_i(), mon_e.re);
          chk("out_q", a_q(), mon_e.im);
        end
      end
      held   = bus_a.s_axis_tvalid && !bus_a.s_axis_tready;
      held_i = a_i();
      held_q = a_q();
      if (bus_a.m_axis_x_tvalid && bus_a.m_axis_y_tvalid && bus_a.m_axis_tready) begin
        for (int k = 0; k < 8; k++) begin
          mon_xr[k] = 0; mon_xm[k] = 0; mon_yr[k] = 0; mon_ym[k] = 0;
        end
        for (int k = 0; k < 4; k++) begin
          mon_xr[k] = int'($signed(bus_a.xi[8*k +: 8]));
          mon_xm[k] = int'($signed(bus_a.xq[8*k +: 8]));
          mon_yr[k] = int'($signed(bus_a.yi[8*k +: 8]));
          mon_ym[k] = int'($signed(bus_a.yq[8*k +: 8]));
        end
        exp_q.push_back(model(mon_xr, mon_xm, mon_yr, mon_ym, 4, bus_a.conj_y));
      end
    end
  end

  task automatic drive_a(input lane_t xr, input lane_t xm, input lane_t yr,
                         input lane_t ym, input bit cj);
    for (int k = 0; k < 4; k++) begin
      bus_a.xi[8*k +: 8] = xr[k][7:0];
      bus_a.xq[8*k +: 8] = xm[k][7:0];
      bus_a.yi[8*k +: 8] = yr[k][7:0];
      bus_a.yq[8*k +: 8] = ym[k][7:0];
    end
    bus_a.conj_y = cj;
  endtask

  // Presents one beat and returns just after the edge that accepts it.
  task automatic send_a(input lane_t xr, input lane_t xm, input lane_t yr,
                        input lane_t ym, input bit cj);
    int n;
    drive_a(xr, xm, yr, ym, cj);
    bus_a.m_axis_x_tvalid = 1'b1;
    bus_a.m_axis_y_tvalid = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus_a.m_axis_tready) break;
    end
    if (n >= 50) chk("accept_timeout_a", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle_a();
    bus_a.m_axis_x_tvalid = 1'b0;
    bus_a.m_axis_y_tvalid = 1'b0;
  endtask

  task automatic drain_a();
    for (int n = 0; n < 60 && exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
    end
    chk("drain_a", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Single beat on A: pins the model to hand values, checks latency and sum.
  task automatic single_a(input string name, input lane_t xr, input lane_t xm,
                          input lane_t yr, input lane_t ym, input bit cj,
                          input longint ei, input longint eq);
    res_t m;
    int   lat;
    m = model(xr, xm, yr, ym, 4, cj);
    chk({name, "_model_i"}, m.re, ei);
    chk({name, "_model_q"}, m.im, eq);
    send_a(xr, xm, yr, ym, cj);
    idle_a();
    lat = 0;
    while (!bus_a.s_axis_tvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, 3);
    chk({name, "_i"}, a_i(), ei);
    chk({name, "_q"}, a_q(), eq);
    drain_a();
  endtask

  // Single beat on B (5 lanes, 12 bit): latency 4 and literal sum.
  task automatic single_b(input string name, input lane_t xr, input lane_t xm,
                          input lane_t yr, input lane_t ym, input bit cj,
                          input longint ei, input longint eq);
    res_t m;
    int   lat;
    int   n;
    m = model(xr, xm, yr, ym, 5, cj);
    chk({name, "_model_i"}, m.re, ei);
    chk({name, "_model_q"}, m.im, eq);
    for (int k = 0; k < 5; k++) begin
      bus_b.xi[12*k +: 12] = xr[k][11:0];
      bus_b.xq[12*k +: 12] = xm[k][11:0];
      bus_b.yi[12*k +: 12] = yr[k][11:0];
      bus_b.yq[12*k +: 12] = ym[k][11:0];
    end
    bus_b.conj_y          = cj;
    bus_b.m_axis_x_tvalid = 1'b1;
    bus_b.m_axis_y_tvalid = 1'b1;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus_b.m_axis_tready) break;
    end
    if (n >= 50) chk("accept_timeout_b", 1, 0);
    @(posedge clk); #1;
    bus_b.m_axis_x_tvalid = 1'b0;
    bus_b.m_axis_y_tvalid = 1'b0;
    lat = 0;
    while (!bus_b.s_axis_tvalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, 4);
    chk({name, "_i"}, b_i(), ei);
    chk({name, "_q"}, b_q(), eq);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_single"}, longint'(bus_b.s_axis_tvalid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lane_t z, xr, xm, yr, ym;
    bit    seen;

    checks = 0;
    errors = 0;
    held   = 1'b0;
    for (int k = 0; k < 8; k++) z[k] = 0;

    rst = 1'b1;
    bus_a.m_axis_x_tvalid = 1'b0; bus_a.m_axis_y_tvalid = 1'b0;
    bus_a.s_axis_tready   = 1'b1; bus_a.conj_y = 1'b0;
    bus_a.xi = '0; bus_a.xq = '0; bus_a.yi = '0; bus_a.yq = '0;
    bus_b.m_axis_x_tvalid = 1'b0; bus_b.m_axis_y_tvalid = 1'b0;
    bus_b.s_axis_tready   = 1'b1; bus_b.conj_y = 1'b0;
    bus_b.xi = '0; bus_b.xq = '0; bus_b.yi = '0; bus_b.yq = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_valid", longint'(bus_a.s_axis_tvalid), 0);
    chk("reset_a_i", a_i(), 0);
    chk("reset_a_q", a_q(), 0);
    chk("reset_b_valid", longint'(bus_b.s_axis_tvalid), 0);
    chk("reset_b_i", b_i(), 0);
    chk("reset_b_q", b_q(), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // x = 1+j2, y = 3+j4 on every lane, plain and conjugated.
    for (int k = 0; k < 8; k++) begin
      xr[k] = 1; xm[k] = 2; yr[k] = 3; ym[k] = 4;
    end
    single_a("basic", xr, xm, yr, ym, 1'b0, -20, 40);
    single_a("conj",  xr, xm, yr, ym, 1'b1, 44, 8);

    // Full-scale negative inputs: the 19-bit result must not wrap.
    for (int k = 0; k < 8; k++) begin
      xr[k] = -128; xm[k] = -128; yr[k] = -128; ym[k] = -128;
    end
    single_a("ext_conj",  xr, xm, yr, ym, 1'b1, 131072, 0);
    single_a("ext_plain", xr, xm, yr, ym, 1'b0, 0, 131072);

    // Only one side valid: nothing may be taken.
    xr = z; xr[0] = 7; yr = z; yr[0] = 3;
    drive_a(xr, z, yr, z, 1'b0);
    bus_a.m_axis_x_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus_a.m_axis_x_tvalid = 1'b0;
    bus_a.m_axis_y_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    idle_a();
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus_a.s_axis_tvalid) seen = 1'b1;
    end
    chk("half_valid_no_output", longint'(seen), 0);
    @(posedge clk); #1;

    // Six back-to-back beats with a five-cycle downstream stall mid-stream.
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          xr = z; xr[0] = k; yr = z; yr[0] = 1;
          send_a(xr, z, yr, z, 1'b0);
        end
        idle_a();
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus_a.s_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_m_tready", longint'(bus_a.m_axis_tready), 0);
        chk("stall_s_tvalid", longint'(bus_a.s_axis_tvalid), 1);
        repeat (3) @(posedge clk);
        #1;
        bus_a.s_axis_tready = 1'b1;
      end
    join
    drain_a();

    // Reset with two beats in flight.
    xr = z; xr[0] = 9; yr = z; yr[0] = 2;
    send_a(xr, z, yr, z, 1'b0);
    xr[0] = 11;
    send_a(xr, z, yr, z, 1'b0);
    idle_a();
    rst = 1'b1;
    #1;
    chk("midrst_valid", longint'(bus_a.s_axis_tvalid), 0);
    chk("midrst_i", a_i(), 0);
    chk("midrst_q", a_q(), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus_a.s_axis_tvalid) seen = 1'b1;
    end
    chk("midrst_no_stale", longint'(seen), 0);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      xr[k] = k + 1; xm[k] = -k; yr[k] = 2; ym[k] = 1;
    end
    // sum over k=0..3 of (k+1 - j k)(2 + j): re = 2(k+1)+k, im = (k+1) - 2k
    single_a("post_rst", xr, xm, yr, ym, 1'b0, 26, -2);

    // Odd lane count on the 5-lane instance.
    for (int k = 0; k < 8; k++) begin
      xr[k] = k; xm[k] = 0; yr[k] = 1; ym[k] = 0;
    end
    single_b("odd5", xr, xm, yr, ym, 1'b0, 10, 0);
    for (int k = 0; k < 8; k++) begin
      xr[k] = -2048; xm[k] = -2048; yr[k] = -2048; ym[k] = -2048;
    end
    single_b("odd5_ext", xr, xm, yr, ym, 1'b1, 41943040, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cpx_dot_prod_pipe
`default_nettype wire
